memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage_if.sv | 20 ++
 rtl/memory_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage_if.sv
// Memory bus bundle between the memory stage (master) and the data memory (slave).
interface memory_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: two-slot load/store stage between execute and writeback.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned word/half accesses are skipped and reported on fault.
module memory_stage (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [31:0]   r1,
    input  logic [31:0]   r2,
    input  logic [31:0]   m_a1,
    input  logic [31:0]   m_a2,
    input  logic [3:0]    m_r1_op,
    input  logic [3:0]    m_r2_op,
    input  logic [4:0]    r_a1,
    input  logic [4:0]    r_a2,
    input  logic [3:0]    r_op,
    input  logic          cres,
    output logic          stall,
    memory_stage_if.master mem,
    output logic          q_valid,
    output logic [31:0]   q1,
    output logic [31:0]   q2,
    output logic [4:0]    qr_a1,
    output logic [4:0]    qr_a2,
    output logic [3:0]    qr_op,
    output logic          fault
);

    localparam logic [3:0] OP_LW = 4'd1;
    localparam logic [3:0] OP_SW = 4'd2;
    localparam logic [3:0] OP_LB = 4'd3;
    localparam logic [3:0] OP_SB = 4'd4;
    localparam logic [3:0] OP_LH = 4'd5;
    localparam logic [3:0] OP_SH = 4'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP1  = 2'd1,
        S_OP2  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic op_valid(input logic [3:0] op);
        return (op != 4'd0) && (op <= 4'd6);
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [3:0] op, input logic [1:0] lo);
        logic [3:0] m;
        case (op)
            OP_LB, OP_SB: m = 4'b0001 << lo;
            OP_LH, OP_SH: m = lo[1] ? 4'b1100 : 4'b0011;
            default:      m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] d);
        logic [31:0] w;
        case (op)
            OP_SB:   w = {4{d[7:0]}};
            OP_SH:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] lo,
                                                 input logic [31:0] rd);
        logic [31:0] v;
        case (op)
            OP_LB:   v = {24'd0, rd[{lo, 3'b000} +: 8]};
            OP_LH:   v = lo[1] ? {16'd0, rd[31:16]} : {16'd0, rd[15:0]};
            default: v = rd;
        endcase
        return v;
    endfunction

`ifdef MEM_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic m;
        case (op)
            OP_LW, OP_SW: m = (lo != 2'b00);
            OP_LH, OP_SH: m = lo[0];
            default:      m = 1'b0;
        endcase
        return m;
    endfunction
`endif

    state_t      state_q, state_d;
    logic [3:0]  eop1_q, eop1_d, eop2_q, eop2_d;
    logic [1:0]  lo1_q, lo1_d;
    logic [31:0] a2_q, a2_d;
    logic [31:0] q1_q, q1_d, q2_q, q2_d;
    logic [4:0]  qr_a1_q, qr_a1_d, qr_a2_q, qr_a2_d;
    logic [3:0]  qr_op_q, qr_op_d;
    logic        fault_q, fault_d, q_valid_q, q_valid_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;

    logic        mis1_s, mis2_s, fault_s;
    logic [3:0]  eop1_s, eop2_s;
    logic        load_bus_s, clear_bus_s;
    logic [3:0]  bus_op_s;
    logic [31:0] bus_addr_s, bus_data_s;

`ifdef MEM_ALIGN_CHECK_EN
    assign mis1_s = misaligned(m_r1_op, m_a1[1:0]);
    assign mis2_s = misaligned(m_r2_op, m_a2[1:0]);
`else
    assign mis1_s = 1'b0;
    assign mis2_s = 1'b0;
`endif

    // Effective op code per slot: zero when squashed, unknown or skipped for alignment.
    assign fault_s = cres && ((op_valid(m_r1_op) && mis1_s) || (op_valid(m_r2_op) && mis2_s));
    assign eop1_s  = (cres && op_valid(m_r1_op) && !mis1_s) ? m_r1_op : 4'd0;
    assign eop2_s  = (cres && op_valid(m_r2_op) && !mis2_s) ? m_r2_op : 4'd0;

    // Next-state, capture and result update; bus actions are requested via load/clear strobes.
    always_comb begin
        state_d     = state_q;
        eop1_d      = eop1_q;
        eop2_d      = eop2_q;
        lo1_d       = lo1_q;
        a2_d        = a2_q;
        q1_d        = q1_q;
        q2_d        = q2_q;
        qr_a1_d     = qr_a1_q;
        qr_a2_d     = qr_a2_q;
        qr_op_d     = qr_op_q;
        fault_d     = fault_q;
        q_valid_d   = 1'b0;
        load_bus_s  = 1'b0;
        clear_bus_s = 1'b0;
        bus_op_s    = 4'd0;
        bus_addr_s  = 32'd0;
        bus_data_s  = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    eop1_d  = eop1_s;
                    eop2_d  = eop2_s;
                    lo1_d   = m_a1[1:0];
                    a2_d    = m_a2;
                    q1_d    = r1;
                    q2_d    = r2;
                    qr_a1_d = r_a1;
                    qr_a2_d = r_a2;
                    qr_op_d = (cres && !fault_s) ? r_op : 4'd0;
                    fault_d = fault_s;
                    if (eop1_s != 4'd0) begin
                        state_d    = S_OP1;
                        load_bus_s = 1'b1;
                        bus_op_s   = eop1_s;
                        bus_addr_s = m_a1;
                        bus_data_s = r1;
                    end else if (eop2_s != 4'd0) begin
                        state_d    = S_OP2;
                        load_bus_s = 1'b1;
                        bus_op_s   = eop2_s;
                        bus_addr_s = m_a2;
                        bus_data_s = r2;
                    end else begin
                        state_d   = S_DONE;
                        q_valid_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OP1: begin
                if (mem.mem_ack) begin
                    if (is_load(eop1_q)) begin
                        q1_d = load_extract(eop1_q, lo1_q, mem.mem_rdata);
                    end else begin
                        q1_d = q1_q;
                    end
                    if (eop2_q != 4'd0) begin
                        state_d    = S_OP2;
                        load_bus_s = 1'b1;
                        bus_op_s   = eop2_q;
                        bus_addr_s = a2_q;
                        bus_data_s = q2_q;
                    end else begin
                        state_d     = S_DONE;
                        q_valid_d   = 1'b1;
                        clear_bus_s = 1'b1;
                    end
                end else begin
                    state_d = S_OP1;
                end
            end
            S_OP2: begin
                if (mem.mem_ack) begin
                    if (is_load(eop2_q)) begin
                        q2_d = load_extract(eop2_q, a2_q[1:0], mem.mem_rdata);
                    end else begin
                        q2_d = q2_q;
                    end
                    state_d     = S_DONE;
                    q_valid_d   = 1'b1;
                    clear_bus_s = 1'b1;
                end else begin
                    state_d = S_OP2;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                clear_bus_s = 1'b1;
            end
        endcase
    end

    // Bus request registers: loaded when an access starts, held until its ack.
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if (load_bus_s) begin
            mem_req_d   = 1'b1;
            mem_we_d    = !is_load(bus_op_s);
            mem_addr_d  = {bus_addr_s[31:2], 2'b00};
            mem_be_d    = lane_mask(bus_op_s, bus_addr_s[1:0]);
            mem_wdata_d = is_load(bus_op_s) ? 32'd0 : store_data(bus_op_s, bus_data_s);
        end else if (clear_bus_s) begin
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = 32'd0;
            mem_wdata_d = 32'd0;
            mem_be_d    = 4'd0;
        end else begin
            mem_req_d   = mem_req_q;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            eop1_q      <= 4'd0;
            eop2_q      <= 4'd0;
            lo1_q       <= 2'd0;
            a2_q        <= 32'd0;
            q1_q        <= 32'd0;
            q2_q        <= 32'd0;
            qr_a1_q     <= 5'd0;
            qr_a2_q     <= 5'd0;
            qr_op_q     <= 4'd0;
            fault_q     <= 1'b0;
            q_valid_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            eop1_q      <= eop1_d;
            eop2_q      <= eop2_d;
            lo1_q       <= lo1_d;
            a2_q        <= a2_d;
            q1_q        <= q1_d;
            q2_q        <= q2_d;
            qr_a1_q     <= qr_a1_d;
            qr_a2_q     <= qr_a2_d;
            qr_op_q     <= qr_op_d;
            fault_q     <= fault_d;
            q_valid_q   <= q_valid_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign stall         = (state_q != S_IDLE);
    assign q_valid       = q_valid_q;
    assign q1            = q1_q;
    assign q2            = q2_q;
    assign qr_a1         = qr_a1_q;
    assign qr_a2         = qr_a2_q;
    assign qr_op         = qr_op_q;
    assign fault         = fault_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_be    = mem_be_q;

endmodule
